// File: rtl/fifo_rd_ctrl.sv
// Read-clock-domain half of an asynchronous FIFO: write-pointer synchroniser,
// binary/Gray read pointers, registered empty flag, fill level and underflow.
module fifo_rd_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AE_THRESH = 2
) (
  input  logic             i_RD_clk,
  input  logic             i_RD_Rst_n,
  input  logic             i_RD_En,
  input  logic             i_Clr_Err,
  input  logic [DEPTH:0]   i_WR_Gray_Ptr,
  input  logic [WIDTH-1:0] i_RAM_Data,
  output logic [DEPTH-1:0] o_RD_Addr,
  output logic [DEPTH:0]   o_RD_Gray_Ptr,
  output logic [WIDTH-1:0] o_RD_Data,
  output logic             o_RD_Valid,
  output logic             o_Empty,
  output logic             o_Almost_Empty,
  output logic [DEPTH:0]   o_RD_Level,
  output logic             o_Underflow
);

  logic [DEPTH:0]   wq1;
  logic [DEPTH:0]   wq2;
  logic [DEPTH:0]   bin;
  logic [DEPTH:0]   gray;
  logic [DEPTH:0]   bin_next;
  logic [DEPTH:0]   gray_next;
  logic [DEPTH:0]   wbin;
  logic [DEPTH:0]   level;
  logic             empty;
  logic             rd_valid;
  logic             underflow;
  logic [WIDTH-1:0] rd_data;
  logic             rd_acc;

  assign rd_acc    = i_RD_En & ~empty;
  assign bin_next  = bin + {{DEPTH{1'b0}}, rd_acc};
  assign gray_next = (bin_next >> 1) ^ bin_next;

  // Plain two-flop synchroniser; only wq2 may be used by downstream logic.
  always_ff @(posedge i_RD_clk or negedge i_RD_Rst_n) begin
    if (!i_RD_Rst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= i_WR_Gray_Ptr;
      wq2 <= wq1;
    end
  end

  // Empty is computed from the next pointer so the last-word read closes it on the same edge.
  always_ff @(posedge i_RD_clk or negedge i_RD_Rst_n) begin
    if (!i_RD_Rst_n) begin
      bin   <= '0;
      gray  <= '0;
      empty <= 1'b1;
    end else begin
      bin   <= bin_next;
      gray  <= gray_next;
      empty <= (gray_next == wq2);
    end
  end

  always_ff @(posedge i_RD_clk or negedge i_RD_Rst_n) begin
    if (!i_RD_Rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= i_RAM_Data;
    end
  end

  // Setting wins over clearing so a simultaneous underflow is never lost.
  always_ff @(posedge i_RD_clk or negedge i_RD_Rst_n) begin
    if (!i_RD_Rst_n) begin
      underflow <= 1'b0;
    end else if (i_RD_En & empty) begin
      underflow <= 1'b1;
    end else if (i_Clr_Err) begin
      underflow <= 1'b0;
    end
  end

  always_comb begin
    wbin = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      wbin[i] = ^(wq2 >> i);
    end
  end

  assign level          = wbin - bin;
  assign o_RD_Level     = level;
  assign o_Almost_Empty = (level <= (DEPTH+1)'(AE_THRESH));
  assign o_RD_Addr      = bin[DEPTH-1:0];
  assign o_RD_Gray_Ptr  = gray;
  assign o_RD_Data      = rd_data;
  assign o_RD_Valid     = rd_valid;
  assign o_Empty        = empty;
  assign o_Underflow    = underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a vector table for the fill/drain/underflow sequence,
// then streamed chunks, reset and full-level sequences against a data scoreboard.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd_en;
  logic       clr_err;
  logic [4:0] wr_gray;
  logic [7:0] ram_data;
  logic [3:0] rd_addr;
  logic [4:0] rd_gray;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_level;
  logic       underflow;

  logic [7:0] ram [16];
  logic [7:0] sb [$];
  logic [4:0] wr_bin;
  logic [4:0] rd_bin;
  int         n_vec = 0;
  int         n_err = 0;

  typedef struct {
    logic       rd_en;
    logic       clr_err;
    logic [4:0] wr_gray;
    logic       exp_empty;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [4:0] exp_level;
    logic       exp_ae;
    logic       exp_uf;
    logic [3:0] exp_addr;
  } vec_t;

  vec_t vecs [13];

  fifo_rd_ctrl #(.WIDTH(8), .DEPTH(4), .AE_THRESH(2)) dut (
    .i_RD_clk       (clk),
    .i_RD_Rst_n     (rst_n),
    .i_RD_En        (rd_en),
    .i_Clr_Err      (clr_err),
    .i_WR_Gray_Ptr  (wr_gray),
    .i_RAM_Data     (ram_data),
    .o_RD_Addr      (rd_addr),
    .o_RD_Gray_Ptr  (rd_gray),
    .o_RD_Data      (rd_data),
    .o_RD_Valid     (rd_valid),
    .o_Empty        (empty),
    .o_Almost_Empty (almost_empty),
    .o_RD_Level     (rd_level),
    .o_Underflow    (underflow)
  );

  always #5 clk = ~clk;

  assign ram_data = ram[rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pops the scoreboard whenever the DUT presents a valid word.
  task automatic check_output();
    logic [7:0] exp;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_valid: got data %0h, expected no valid", rd_data);
      end else begin
        exp = sb.pop_front();
        check("rd_data", rd_data, exp);
      end
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    ram[wr_bin[3:0]] = d;
    sb.push_back(d);
    wr_bin  = wr_bin + 5'd1;
    wr_gray = wr_bin ^ (wr_bin >> 1);
  endtask

  // Writes n words, waits for them to cross the synchroniser, then drains them.
  task automatic stream_chunk(input int n);
    logic [4:0] prev_gray;
    for (int k = 0; k < n; k++) begin
      write_word(8'($urandom));
      tick();
      check_output();
    end
    repeat (3) tick();
    check("chunk_not_empty", empty, 1'b0);
    check("chunk_level", rd_level, 5'(n));
    for (int k = 0; k < n; k++) begin
      rd_en     = 1'b1;
      prev_gray = rd_gray;
      tick();
      rd_bin = rd_bin + 5'd1;
      check("stream_valid", rd_valid, 1'b1);
      check_output();
      check("gray_one_bit", $countones(rd_gray ^ prev_gray), 1);
      check("stream_addr", rd_addr, rd_bin[3:0]);
    end
    rd_en = 1'b0;
    check("chunk_empty", empty, 1'b1);
    tick();
    check("chunk_idle_valid", rd_valid, 1'b0);
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < 13; i++) begin
      rd_en   = vecs[i].rd_en;
      clr_err = vecs[i].clr_err;
      wr_gray = vecs[i].wr_gray;
      if (vecs[i].exp_valid) sb.push_back(vecs[i].exp_data);
      tick();
      check($sformatf("v%0d_empty", i), empty, vecs[i].exp_empty);
      check($sformatf("v%0d_valid", i), rd_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_level", i), rd_level, vecs[i].exp_level);
      check($sformatf("v%0d_ae", i), almost_empty, vecs[i].exp_ae);
      check($sformatf("v%0d_uf", i), underflow, vecs[i].exp_uf);
      check($sformatf("v%0d_addr", i), rd_addr, vecs[i].exp_addr);
      check_output();
    end
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    //          rd clr wgray  emp val data   lvl  ae uf addr
    vecs[0]  = '{1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 8'h00, 5'd1, 1'b1, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 8'h00, 5'd1, 1'b1, 1'b0, 4'd0};
    vecs[3]  = '{1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h00, 5'd2, 1'b1, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h00, 5'd3, 1'b0, 1'b0, 4'd0};
    vecs[5]  = '{1'b1, 1'b0, 5'd2, 1'b0, 1'b1, 8'hA0, 5'd2, 1'b1, 1'b0, 4'd1};
    vecs[6]  = '{1'b1, 1'b0, 5'd2, 1'b0, 1'b1, 8'hA1, 5'd1, 1'b1, 1'b0, 4'd2};
    vecs[7]  = '{1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 8'hA2, 5'd0, 1'b1, 1'b0, 4'd3};
    vecs[8]  = '{1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 4'd3};
    vecs[9]  = '{1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 4'd3};
    vecs[10] = '{1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 4'd3};
    vecs[11] = '{1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 4'd3};
    vecs[12] = '{1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 4'd3};

    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0] = 8'hA0;
    ram[1] = 8'hA1;
    ram[2] = 8'hA2;
    rst_n   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    wr_gray = 5'd0;
    wr_bin  = 5'd0;
    rd_bin  = 5'd0;

    repeat (3) tick();
    check("rst_empty", empty, 1'b1);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_addr", rd_addr, 4'd0);
    check("rst_level", rd_level, 5'd0);
    check("rst_uf", underflow, 1'b0);
    check("rst_ae", almost_empty, 1'b1);
    check("rst_data", rd_data, 8'h00);
    rst_n = 1'b1;

    apply_stimulus();
    wr_bin = 5'd3;
    rd_bin = 5'd3;

    for (int c = 0; c < 5; c++) stream_chunk(8);
    check("stream_rdbin", rd_addr, 4'd11);

    // Asynchronous reset in the middle of a drain.
    for (int k = 0; k < 4; k++) begin
      write_word(8'($urandom));
      tick();
    end
    repeat (3) tick();
    rd_en = 1'b1;
    tick();
    check_output();
    tick();
    check_output();
    #2;
    rst_n   = 1'b0;
    wr_bin  = 5'd0;
    wr_gray = 5'd0;
    #1;
    check("mrst_empty", empty, 1'b1);
    check("mrst_valid", rd_valid, 1'b0);
    check("mrst_data", rd_data, 8'h00);
    check("mrst_addr", rd_addr, 4'd0);
    check("mrst_gray", rd_gray, 5'd0);
    check("mrst_level", rd_level, 5'd0);
    check("mrst_ae", almost_empty, 1'b1);
    check("mrst_uf", underflow, 1'b0);
    sb.delete();
    rd_en = 1'b0;
    repeat (2) tick();
    rst_n  = 1'b1;
    rd_bin = 5'd0;
    tick();

    // Fill all 16 words at once and drain, watching the almost-empty threshold.
    for (int k = 0; k < 16; k++) begin
      ram[k] = 8'($urandom);
      sb.push_back(ram[k]);
    end
    wr_bin  = 5'd16;
    wr_gray = 5'b11000;
    repeat (3) tick();
    check("full_level", rd_level, 5'd16);
    check("full_ae", almost_empty, 1'b0);
    check("full_empty", empty, 1'b0);
    for (int k = 0; k < 16; k++) begin
      rd_en = 1'b1;
      tick();
      check_output();
      check("full_drain_level", rd_level, 5'(15 - k));
      check("full_drain_ae", almost_empty, (15 - k) <= 2);
    end
    rd_en = 1'b0;
    check("full_drained_empty", empty, 1'b1);
    tick();
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
